// File: rtl/chime_scheduler.sv
// Arbitrates one music player between alarm, chime, key-tone and manual requests with pre-emption and queueing.
// Start asserts 3 edges after a request rise is sampled when idle; every output is a register.
module chime_scheduler #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          MSC_N    = 5,
    parameter logic [15:0] ALM_MS   = 16'd30000,
    parameter logic [15:0] CHM_MS   = 16'd2000,
    parameter logic [15:0] KEY_MS   = 16'd100,
    parameter logic [15:0] MAN_MS   = 16'd60000
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             req_alarm,
    input  logic             req_chime,
    input  logic             req_key,
    input  logic             req_man,
    input  logic [2:0]       song_sel,
    input  logic [9:0]       vol_user,
    input  logic             stop,
    output logic [MSC_N-1:0] start,
    output logic [9:0]       volume,
    output logic             busy,
    output logic [1:0]       active_src,
    output logic             done
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PS_LAST  = PW'(DIV - 1);
    localparam logic [MSC_N-1:0] SONG_ALM = MSC_N'(1);
    localparam logic [MSC_N-1:0] SONG_CHM = MSC_N'(2);
    localparam logic [MSC_N-1:0] SONG_KEY = MSC_N'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       req_q, req_p_q;
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       src_q, src_d;
    logic [MSC_N-1:0] song_q, song_d;
    logic [9:0]       vol_lat_q, vol_lat_d;
    logic [15:0]      dur_q, dur_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic [15:0]      ms_q, ms_d;
    logic [MSC_N-1:0] start_q, start_d;
    logic [9:0]       volume_q, volume_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       evt;
    logic [3:0]       pend_set;
    logic [3:0]       pend_clr;
    logic             any_pend;
    logic [1:0]       hi_src;
    logic             tick;
    logic [MSC_N-1:0] man_oh;
    int               man_idx;

    // Bit order everywhere is priority order: 3 alarm, 2 chime, 1 key, 0 manual.
    assign evt      = req_q & ~req_p_q;
    assign any_pend = |pend_q;
    assign tick     = (ps_q == PS_LAST);

    always_comb begin
        hi_src = 2'd0;
        if (pend_q[3]) begin
            hi_src = 2'd3;
        end else if (pend_q[2]) begin
            hi_src = 2'd2;
        end else if (pend_q[1]) begin
            hi_src = 2'd1;
        end
    end

    always_comb begin
        man_oh  = '0;
        man_idx = (int'(song_sel) >= MSC_N) ? (MSC_N - 1) : int'(song_sel);
        for (int i = 0; i < MSC_N; i++) begin
            man_oh[i] = (i == man_idx);
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_clr  = '0;
        src_d     = src_q;
        song_d    = song_q;
        vol_lat_d = vol_lat_q;
        dur_d     = dur_q;
        ps_d      = ps_q;
        ms_d      = ms_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    src_d            = hi_src;
                    pend_clr[hi_src] = 1'b1;
                    vol_lat_d        = vol_user;
                    state_d          = LOAD;
                    case (hi_src)
                        2'd3: begin
                            song_d    = SONG_ALM;
                            vol_lat_d = 10'h3FF;
                            dur_d     = ALM_MS;
                        end
                        2'd2: begin
                            song_d = SONG_CHM;
                            dur_d  = CHM_MS;
                        end
                        2'd1: begin
                            song_d = SONG_KEY;
                            dur_d  = KEY_MS;
                        end
                        default: begin
                            song_d = man_oh;
                            dur_d  = MAN_MS;
                        end
                    endcase
                end
            end
            LOAD: begin
                ps_d    = '0;
                ms_d    = '0;
                state_d = PLAY;
            end
            PLAY: begin
                // A strictly higher pending source kills the current sound; it is not re-queued.
                if (any_pend && (hi_src > src_q)) begin
                    state_d = IDLE;
                end else if (tick) begin
                    ps_d = '0;
                    ms_d = ms_q + 16'd1;
                    if (ms_q == dur_q - 16'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ps_d = ps_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        pend_set = evt;
        if (state_q != IDLE) begin
            pend_set[1] = 1'b0;
        end
        pend_d = stop ? 4'b0000 : ((pend_q & ~pend_clr) | pend_set);

        start_d  = (state_d == PLAY) ? song_d : '0;
        volume_d = (state_d == PLAY) ? vol_lat_d : 10'h000;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            req_p_q   <= '0;
            pend_q    <= '0;
            src_q     <= '0;
            song_q    <= '0;
            vol_lat_q <= '0;
            dur_q     <= '0;
            ps_q      <= '0;
            ms_q      <= '0;
            start_q   <= '0;
            volume_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= {req_alarm, req_chime, req_key, req_man};
            req_p_q   <= req_q;
            pend_q    <= pend_d;
            src_q     <= src_d;
            song_q    <= song_d;
            vol_lat_q <= vol_lat_d;
            dur_q     <= dur_d;
            ps_q      <= ps_d;
            ms_q      <= ms_d;
            start_q   <= start_d;
            volume_q  <= volume_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign start      = start_q;
    assign volume     = volume_q;
    assign busy       = busy_q;
    assign active_src = src_q;
    assign done       = done_q;

endmodule

// File: tb/tb_chime_scheduler.sv
// Scoreboard bench for chime_scheduler: each expected sound is queued when stimulus is driven, checked when it ends.
module tb_chime_scheduler;

    logic       sysclk;
    logic       rst;
    logic       req_alarm, req_chime, req_key, req_man;
    logic [2:0] song_sel;
    logic [9:0] vol_user;
    logic       stop;
    logic [4:0] start;
    logic [9:0] volume;
    logic       busy;
    logic [1:0] active_src;
    logic       done;

    chime_scheduler #(
        .CLK_FREQ(4000),
        .MSC_N   (5),
        .ALM_MS  (16'd5),
        .CHM_MS  (16'd3),
        .KEY_MS  (16'd2),
        .MAN_MS  (16'd10)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .req_alarm (req_alarm),
        .req_chime (req_chime),
        .req_key   (req_key),
        .req_man   (req_man),
        .song_sel  (song_sel),
        .vol_user  (vol_user),
        .stop      (stop),
        .start     (start),
        .volume    (volume),
        .busy      (busy),
        .active_src(active_src),
        .done      (done)
    );

    // Cycle lengths with DIV = 4
    localparam int ALM_LEN = 20;
    localparam int CHM_LEN = 12;
    localparam int KEY_LEN = 8;
    localparam int MAN_LEN = 40;

    typedef struct {
        logic [4:0] song;
        logic [9:0] vol;
        logic [1:0] src;
        int         t0;
        int         len;
        logic       done;
    } snd_t;

    snd_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic       in_snd   = 1'b0;
    logic [4:0] o_song;
    logic [9:0] o_vol;
    logic [1:0] o_src;
    int         o_t0;
    logic       unstable;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [4:0] song, input logic [9:0] vol, input logic [1:0] src,
                        input int t0, input int len, input logic dn);
        snd_t e;
        e.song = song; e.vol = vol; e.src = src; e.t0 = t0; e.len = len; e.done = dn;
        sb.push_back(e);
    endtask

    // Called at a drive point (just after a rising edge); returns the cycle the request rose in.
    task automatic drive_req(input logic [3:0] m, output int n);
        {req_alarm, req_chime, req_key, req_man} = m;
        n = cyc;
        @(posedge sysclk); #1;
        {req_alarm, req_chime, req_key, req_man} = 4'b0000;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge sysclk); #1;
        end
    endtask

    // Monitor samples on the falling edge; a sound is compared against the scoreboard when it ends.
    always @(negedge sysclk) begin
        snd_t e;
        if (start != 5'b0) begin
            if (!in_snd) begin
                in_snd   = 1'b1;
                o_t0     = cyc;
                o_song   = start;
                o_vol    = volume;
                o_src    = active_src;
                unstable = 1'b0;
            end else if (start != o_song || volume != o_vol) begin
                unstable = 1'b1;
            end
            if (!busy) unstable = 1'b1;
        end else if (in_snd) begin
            in_snd = 1'b0;
            if (sb.size() == 0) begin
                check("unexpected_sound", {27'b0, o_song}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("song",      {27'b0, o_song}, {27'b0, e.song});
                check("volume",    {22'b0, o_vol},  {22'b0, e.vol});
                check("src",       {30'b0, o_src},  {30'b0, e.src});
                check("start_cyc", o_t0,            e.t0);
                check("length",    cyc - o_t0,      e.len);
                check("done_end",  {31'b0, done},   {31'b0, e.done});
                check("busy_end",  {31'b0, busy},   32'h0);
                check("stable",    {31'b0, unstable}, 32'h0);
            end
        end else if (done) begin
            check("done_stray", {31'b0, done}, 32'h0);
        end
    end

    initial begin
        int n, p, q, r, a0;
        rst = 1'b1;
        {req_alarm, req_chime, req_key, req_man} = 4'b0000;
        song_sel = 3'd0;
        vol_user = 10'h040;
        stop     = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_start",  {27'b0, start},      32'h0);
        check("rst_volume", {22'b0, volume},     32'h0);
        check("rst_busy",   {31'b0, busy},       32'h0);
        check("rst_src",    {30'b0, active_src}, 32'h0);
        check("rst_done",   {31'b0, done},       32'h0);
        rst = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;

        // Chime alone; vol_user changes mid-play but the latched volume must hold
        drive_req(4'b0100, n);
        push(5'b00010, 10'h040, 2'd2, n + 4, CHM_LEN, 1'b1);
        wait_until(n + 8);
        vol_user = 10'h155;
        wait_until(n + 4 + CHM_LEN + 5);

        // Key tone while idle
        drive_req(4'b0010, n);
        push(5'b00100, 10'h155, 2'd1, n + 4, KEY_LEN, 1'b1);
        wait_until(n + 4 + KEY_LEN + 5);

        // Manual with clamped song index, pre-empted by alarm
        song_sel = 3'd7;
        drive_req(4'b0001, n);
        wait_until(n + 10);
        p  = cyc;
        a0 = p + 5;
        push(5'b10000, 10'h155, 2'd0, n + 4, p + 3 - (n + 4), 1'b0);
        push(5'b00001, 10'h3FF, 2'd3, a0, ALM_LEN, 1'b1);
        drive_req(4'b1000, n);

        // During alarm: key dropped, chime queued behind alarm
        wait_until(p + 10);
        drive_req(4'b0010, n);
        wait_until(p + 13);
        drive_req(4'b0100, n);
        push(5'b00010, 10'h155, 2'd2, a0 + ALM_LEN + 2, CHM_LEN, 1'b1);
        wait_until(a0 + ALM_LEN + 2 + CHM_LEN + 6);

        // Stop during alarm with chime pending: nothing plays afterwards
        drive_req(4'b1000, n);
        a0 = n + 4;
        wait_until(n + 6);
        drive_req(4'b0100, n);
        wait_until(a0 + 8);
        q = cyc;
        push(5'b00001, 10'h3FF, 2'd3, a0, q + 1 - a0, 1'b0);
        stop = 1'b1;
        @(posedge sysclk); #1;
        stop = 1'b0;
        check("stop_start", {27'b0, start}, 32'h0);
        wait_until(q + 50);

        // Simultaneous alarm, chime, manual
        song_sel = 3'd2;
        vol_user = 10'h0AA;
        drive_req(4'b1101, n);
        push(5'b00001, 10'h3FF, 2'd3, n + 4,  ALM_LEN, 1'b1);
        push(5'b00010, 10'h0AA, 2'd2, n + 26, CHM_LEN, 1'b1);
        push(5'b00100, 10'h0AA, 2'd0, n + 40, MAN_LEN, 1'b1);
        wait_until(n + 40 + MAN_LEN + 6);

        // Asynchronous reset mid-play
        song_sel = 3'd1;
        drive_req(4'b0001, n);
        wait_until(n + 9);
        r = cyc;
        push(5'b00010, 10'h0AA, 2'd0, n + 4, r - (n + 4), 1'b0);
        rst = 1'b1;
        #1;
        check("arst_start",  {27'b0, start},  32'h0);
        check("arst_volume", {22'b0, volume}, 32'h0);
        check("arst_busy",   {31'b0, busy},   32'h0);
        check("arst_done",   {31'b0, done},   32'h0);
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        wait_until(cyc + 30);

        check("sb_empty", sb.size(), 32'h0);
        check("idle_end", {31'b0, in_snd}, 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/chime_scheduler.md
Name: chime_scheduler

Overview:
- Arbitrates the clock's single music player between four sound requesters: alarm, hourly chime, key-press tone and manual play.
- For the winning requester it drives the player's one-hot song-select and volume inputs.
- It times each playback with an internal millisecond timebase, handles priority pre-emption and queues pending requests.
- It sits between the clock/alarm/key logic and the player interface.

Parameters:
- CLK_FREQ, 50_000_000, sysclk frequency in Hz. Ms divider DIV = CLK_FREQ/1000.
- MSC_N, 5, number of songs, i.e. width of the one-hot start vector.
- ALM_MS, 30000, alarm playback length in ms.
- CHM_MS, 2000, chime playback length in ms.
- KEY_MS, 100, key-tone playback length in ms.
- MAN_MS, 60000, manual playback length in ms.
- All lengths are 16-bit and must be ≥1.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_alarm  in  1  alarm request; rising edge is an event. Priority 3 (highest).
- req_chime  in  1  hourly chime request; rising edge. Priority 2.
- req_key  in  1  key tone request; rising edge. Priority 1. Not queued.
- req_man  in  1  manual play request; rising edge. Priority 0.
- song_sel  in  3  manual song index, sampled at launch. Values ≥ MSC_N are clamped to MSC_N-1.
- vol_user  in  10  user volume for non-alarm sounds.
- stop  in  1  level; cancels current playback and all pending requests.
- start  out  MSC_N  one-hot song select to the player; all zero = silent.
- volume  out  10  volume to the player.
- busy  out  1  high in LOAD or PLAY.
- active_src  out  2  source being served: 3 alarm, 2 chime, 1 key, 0 manual. Valid while busy.
- done  out  1  one-cycle pulse when a playback expires naturally.

Behaviour:
- Reset values: start=0, volume=0, busy=0, active_src=0, done=0. Pending bits, edge registers, prescaler, ms counter and FSM (IDLE) are all cleared. Reset is honoured immediately, including mid-play.
- Edge detect: each req_* is registered. An event occurs when the current sample is 1 and the previous sample was 0. Inputs are synchronous to sysclk.
- Pending: an event sets that source's pending bit on the next edge. A key event while busy is discarded. An event coinciding with its own pending-bit clear leaves the bit set.
- Song map:
  - alarm → bit 0
  - chime → bit 1
  - key → bit 2
  - manual → bit song_sel (clamped)
- Volume map: alarm uses 10'h3FF; all others use vol_user, latched at launch.
- FSM:
  - IDLE:
    - If any pending bit is set, latch the highest-priority source and clear its pending bit.
    - Latch song and volume, then go to LOAD.
    - start=0 throughout.
  - LOAD:
    - Lasts one cycle with start=0.
    - Prescaler and ms counter are set to 0; go to PLAY.
  - PLAY:
    - start=latched one-hot, volume=latched value.
    - The prescaler counts 0..DIV-1 and produces a tick on wrap; each tick increments the ms counter.
    - On the tick where ms==duration-1, go to IDLE and pulse done in the following cycle. PLAY therefore lasts exactly duration×DIV cycles.
- Pre-emption:
  - In PLAY, a pending source with strictly higher priority than active_src aborts the current sound: go to IDLE with no done pulse.
  - The aborted request is discarded, not re-queued.
  - Equal- or lower-priority events stay pending until the current sound ends.
- Silence gap: at least 2 consecutive cycles of start=0 (IDLE and LOAD) separate any two sounds, so the player always sees a fresh rising edge.
- stop: in any state, go to IDLE and clear all pending bits; no done pulse. stop wins over simultaneous events in the same cycle.
- Latency: when idle with nothing pending, start asserts on the 3rd rising edge after the edge that samples the request rising.
- Outputs are registered.

Test Plan:
- Reset: assert rst mid-stream → start=0, volume=0, busy=0, done=0 immediately (async); no output activity until a new request arrives.
- Chime (CLK_FREQ=4000, CHM_MS=3, vol_user=10'h040): pulse req_chime → start=5'b00010 and volume=10'h040 for exactly 12 cycles, then start=0; done high 1 cycle; busy falls with start.
- Manual clamp plus pre-emption: song_sel=7, req_man → start=5'b10000. Mid-play req_alarm → start=0 for exactly 2 cycles, then 5'b00001 with volume=10'h3FF. Manual is not resumed; no done for manual.
- Queueing: during alarm, pulse req_chime → chime starts only after alarm expiry and done, with ≥2 zero cycles between; order alarm, then chime.
- Key drop and stop: while busy, pulse req_key → no key tone ever plays. With chime pending during alarm, assert stop → start=0 next cycle, nothing plays afterwards, done stays 0.
- Simultaneous: req_alarm, req_chime and req_man rise in the same cycle → served alarm (bit 0), then chime, then manual.
